// File: rtl/avalon_mem_master.sv
// Avalon-MM master that serialises MIPS instruction-fetch and data requests onto one bus port.
// Optional bus-stall watchdog enabled by defining WAIT_TIMEOUT_EN.
module avalon_mem_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_rdata,
  output logic        instr_valid,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        busy,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;
  typedef enum logic {TAG_INSTR, TAG_DATA} tag_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state, state_d;
  tag_t        tag, tag_d;
  logic [31:0] address_d, writedata_d, instr_rdata_d, data_rdata_d;
  logic [3:0]  byteenable_d;
  logic        read_d, write_d, instr_valid_d, data_valid_d;
  logic        timeout_hit;

`ifdef WAIT_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  // The abort fires on the wait cycle that brings the count to TIMEOUT_CYCLES.
  assign timeout_hit = (state == ISSUE) && waitrequest && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= (state == ISSUE && waitrequest && !timeout_hit) ? wait_cnt + 1'b1 : '0;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state;
    tag_d         = tag;
    address_d     = address;
    read_d        = read;
    write_d       = write;
    writedata_d   = writedata;
    byteenable_d  = byteenable;
    instr_rdata_d = instr_rdata;
    data_rdata_d  = data_rdata;
    instr_valid_d = 1'b0;
    data_valid_d  = 1'b0;

    case (state)
      IDLE: begin
        if (data_req) begin
          tag_d        = TAG_DATA;
          address_d    = data_addr & ~32'h3;
          writedata_d  = data_wdata;
          byteenable_d = data_be;
          read_d       = !data_we;
          write_d      = data_we;
          state_d      = ISSUE;
        end else if (instr_req) begin
          tag_d        = TAG_INSTR;
          address_d    = instr_addr & ~32'h3;
          byteenable_d = 4'b1111;
          read_d       = 1'b1;
          write_d      = 1'b0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (!waitrequest) begin
          read_d       = 1'b0;
          write_d      = 1'b0;
          state_d      = write ? DONE : RESP;
          data_valid_d = write;
        end else if (timeout_hit) begin
          read_d        = 1'b0;
          write_d       = 1'b0;
          state_d       = DONE;
          instr_valid_d = (tag == TAG_INSTR);
          data_valid_d  = (tag == TAG_DATA);
          // An aborted read returns zero; an aborted store leaves data_rdata alone.
          if (tag == TAG_INSTR) instr_rdata_d = '0;
          else if (!write)      data_rdata_d  = '0;
        end
      end
      RESP: begin
        state_d = DONE;
        if (tag == TAG_DATA) begin
          data_rdata_d = readdata;
          data_valid_d = 1'b1;
        end else begin
          instr_rdata_d = readdata;
          instr_valid_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tag         <= TAG_INSTR;
      address     <= RESET_VECTOR;
      read        <= 1'b0;
      write       <= 1'b0;
      writedata   <= '0;
      byteenable  <= 4'b1111;
      instr_rdata <= '0;
      data_rdata  <= '0;
      instr_valid <= 1'b0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      tag         <= tag_d;
      address     <= address_d;
      read        <= read_d;
      write       <= write_d;
      writedata   <= writedata_d;
      byteenable  <= byteenable_d;
      instr_rdata <= instr_rdata_d;
      data_rdata  <= data_rdata_d;
      instr_valid <= instr_valid_d;
      data_valid  <= data_valid_d;
      busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_avalon_mem_master.sv
// Self-checking bench for avalon_mem_master: transaction scoreboard plus directed scenarios.
// Define WAIT_TIMEOUT_EN for both files to exercise the stall watchdog.
module tb_avalon_mem_master;

`ifdef WAIT_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = '0;
  logic [31:0] instr_rdata;
  logic        instr_valid;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [3:0]  data_be = '0;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        busy;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata = 32'hA5A5A5A5;
  logic        waitrequest = 1'b0;
  logic        timeout_err;

  avalon_mem_master #(.TIMEOUT_CYCLES(TO), .RESET_VECTOR(32'hBFC00000)) dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_rdata(instr_rdata), .instr_valid(instr_valid),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_be(data_be), .data_rdata(data_rdata), .data_valid(data_valid), .busy(busy),
    .address(address), .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .waitrequest(waitrequest), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave memory contents.
  function automatic logic [31:0] slave_mem(input logic [31:0] a);
    case (a)
      32'hBFC00004: return 32'h24020005;
      32'h00000010: return 32'h12345678;
      default:      return a ^ 32'h5A5A0000;
    endcase
  endfunction

  // Slave: stalls the first wait_cfg cycles of each bus op, returns data one cycle after accept.
  int wait_cfg = 0;
  always @(posedge clk) begin
    logic        acc;
    logic [31:0] a;
    int          wcnt;
    acc = read && !waitrequest;
    a   = address;
    #1;
    readdata = acc ? slave_mem(a) : 32'hA5A5A5A5;
    if (read || write) begin
      waitrequest = (wcnt < wait_cfg);
      wcnt++;
    end else begin
      waitrequest = 1'b0;
      wcnt = 0;
    end
  end

  // Transaction-level model of what the master owes the core and the bus.
  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    bit          abort;
  } txn_t;

  txn_t        q[$];
  bit          started, finished;
  int          waits, end_cyc;
  logic [31:0] exp_i, exp_d;
  bit          exp_terr;
  int          bus_cycles = 0;
  int          completions = 0;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      started = 0; finished = 0; waits = 0;
      exp_i = '0; exp_d = '0; exp_terr = 0;
    end else begin
      check("rw_exclusive", {31'b0, read && write}, 32'd0);
      if (read || write) begin
        bus_cycles++;
        if (q.size() == 0 || finished) check("spurious_bus", 32'd1, 32'd0);
        else begin
          check("bus_addr", address, q[0].addr);
          check("bus_write", {31'b0, write}, {31'b0, q[0].we});
          check("bus_be", {28'b0, byteenable}, {28'b0, q[0].be});
          if (q[0].we) check("bus_wdata", writedata, q[0].wdata);
          started = 1;
          if (!waitrequest) begin
            finished = 1;
            end_cyc  = cyc;
          end else waits++;
        end
      end else if (started && !finished) begin
        if (q.size() > 0 && q[0].abort && waits == TO) begin
          finished = 1;
          end_cyc  = cyc - 1;
        end else check("bus_dropped", 32'd1, 32'd0);
      end

      check("one_valid", {31'b0, instr_valid && data_valid}, 32'd0);
      if (instr_valid || data_valid) begin
        if (q.size() == 0 || !finished) check("spurious_valid", 32'd1, 32'd0);
        else begin
          check("valid_tag", {31'b0, data_valid}, {31'b0, q[0].is_data});
          check("valid_latency", cyc - end_cyc, (!q[0].we && !q[0].abort) ? 32'd2 : 32'd1);
          if (!q[0].we) begin
            if (q[0].is_data) exp_d = q[0].abort ? 32'h0 : q[0].rdata;
            else              exp_i = q[0].abort ? 32'h0 : q[0].rdata;
          end
          if (q[0].abort) exp_terr = 1;
          completions++;
          void'(q.pop_front());
          started = 0; finished = 0; waits = 0;
        end
      end
      check("instr_rdata", instr_rdata, exp_i);
      check("data_rdata", data_rdata, exp_d);
      check("timeout_err", {31'b0, timeout_err}, {31'b0, exp_terr});
      if (read || write || instr_valid || data_valid) check("busy", {31'b0, busy}, 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    instr_req = 1'b0;
    data_req = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_instr(input logic [31:0] a, input logic [31:0] exp_a, input logic [31:0] rd);
    txn_t t;
    t = '{is_data: 0, we: 0, addr: exp_a, wdata: '0, be: 4'hF, rdata: rd, abort: 0};
    q.push_back(t);
    instr_addr = a;
    instr_req  = 1'b1;
  endtask

  task automatic start_data(input bit we, input logic [31:0] a, input logic [31:0] exp_a,
                            input logic [31:0] wd, input logic [3:0] be,
                            input logic [31:0] rd, input bit abort);
    txn_t t;
    t = '{is_data: 1, we: we, addr: exp_a, wdata: wd, be: be, rdata: rd, abort: abort};
    q.push_back(t);
    data_we    = we;
    data_addr  = a;
    data_wdata = wd;
    data_be    = be;
    data_req   = 1'b1;
  endtask

  // Waits (bounded) for the tagged valid, checks its latency, drops that request at the edge ending DONE.
  task automatic wait_valid(input string name, input bit is_data, input int t0, input int exp_lat);
    bit got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (is_data ? data_valid : instr_valid) got = 1;
    end
    if (!got) check({name, "_valid_timeout"}, 32'd0, 32'd1);
    else      check({name, "_latency"}, cyc - t0, exp_lat);
    tick();
    if (is_data) data_req = 1'b0;
    else         instr_req = 1'b0;
  endtask

  initial begin
    int t0, b0, c0;
    do_reset();
    check("rst_read", {31'b0, read}, 32'd0);
    check("rst_write", {31'b0, write}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_address", address, 32'hBFC00000);
    check("rst_byteenable", {28'b0, byteenable}, 32'hF);
    check("rst_writedata", writedata, 32'h0);
    check("rst_instr_rdata", instr_rdata, 32'h0);
    check("rst_data_rdata", data_rdata, 32'h0);
    check("rst_valids", {30'b0, instr_valid, data_valid}, 32'd0);
    check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);

    // Fetch, no wait.
    tick();
    b0 = bus_cycles; c0 = completions; t0 = cyc;
    start_instr(32'hBFC00004, 32'hBFC00004, 32'h24020005);
    tick();
    check("t1_read", {31'b0, read}, 32'd1);
    check("t1_address", address, 32'hBFC00004);
    wait_valid("t1", 0, t0, 3);
    check("t1_instr_rdata", instr_rdata, 32'h24020005);
    check("t1_bus_cycles", bus_cycles - b0, 32'd1);
    check("t1_completions", completions - c0, 32'd1);

    // Store with three wait cycles.
    tick();
    wait_cfg = 3;
    b0 = bus_cycles; t0 = cyc;
    start_data(1, 32'h00000102, 32'h00000100, 32'hDEADBEEF, 4'b0011, 32'h0, 0);
    wait_valid("t2", 1, t0, 5);
    check("t2_bus_cycles", bus_cycles - b0, 32'd4);
    check("t2_data_rdata", data_rdata, 32'h0);

    // Load with two wait cycles.
    tick();
    wait_cfg = 2;
    b0 = bus_cycles; t0 = cyc;
    start_data(0, 32'h00000203, 32'h00000200, 32'h0, 4'b0100, 32'h5A5A0200, 0);
    wait_valid("t2b", 1, t0, 5);
    check("t2b_data_rdata", data_rdata, 32'h5A5A0200);
    check("t2b_bus_cycles", bus_cycles - b0, 32'd3);
    wait_cfg = 0;

    // Simultaneous requests: data first, fetch after.
    tick();
    b0 = bus_cycles; c0 = completions; t0 = cyc;
    start_data(0, 32'h00000010, 32'h00000010, 32'h0, 4'b1111, 32'h12345678, 0);
    start_instr(32'h00400008, 32'h00400008, 32'h5A1A0008);
    wait_valid("t3_data", 1, t0, 3);
    check("t3_data_rdata", data_rdata, 32'h12345678);
    wait_valid("t3_instr", 0, t0, 7);
    check("t3_instr_rdata", instr_rdata, 32'h5A1A0008);
    check("t3_bus_cycles", bus_cycles - b0, 32'd2);
    check("t3_completions", completions - c0, 32'd2);

    // Held request dropped at the edge ending DONE is issued once.
    tick();
    b0 = bus_cycles; t0 = cyc;
    start_instr(32'h00400023, 32'h00400020, 32'h5A1A0020);
    wait_valid("t4", 0, t0, 3);
    tick(); tick(); tick();
    check("t4_bus_cycles", bus_cycles - b0, 32'd1);
    check("t4_busy_after", {31'b0, busy}, 32'd0);

    // Reset while the bus is stalled.
    wait_cfg = 1000;
    c0 = completions;
    start_instr(32'h00001000, 32'h00001000, 32'h5A5A1000);
    tick(); tick(); tick();
    check("t5_read_before", {31'b0, read}, 32'd1);
    do_reset();
    wait_cfg = 0;
    check("t5_read", {31'b0, read}, 32'd0);
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_address", address, 32'hBFC00000);
    check("t5_instr_rdata", instr_rdata, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    check("t5_no_valid", completions - c0, 32'd0);

`ifdef WAIT_TIMEOUT_EN
    // Load first so data_rdata is non-zero, then a load that never gets accepted.
    start_data(0, 32'h00000040, 32'h00000040, 32'h0, 4'hF, 32'h5A5A0040, 0);
    t0 = cyc;
    wait_valid("t6_pre", 1, t0, 3);
    check("t6_pre_rdata", data_rdata, 32'h5A5A0040);
    tick();
    wait_cfg = 1000;
    b0 = bus_cycles; t0 = cyc;
    start_data(0, 32'h00000030, 32'h00000030, 32'h0, 4'hF, 32'h0, 1);
    wait_valid("t6", 1, t0, 5);
    check("t6_bus_cycles", bus_cycles - b0, 32'd4);
    check("t6_data_rdata", data_rdata, 32'h0);
    check("t6_timeout_err", {31'b0, timeout_err}, 32'd1);
    wait_cfg = 0;
    for (int i = 0; i < 4; i++) tick();
    check("t6_sticky", {31'b0, timeout_err}, 32'd1);
    do_reset();
    check("t6_cleared", {31'b0, timeout_err}, 32'd0);
`endif

    tick(); tick();
    check("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
